commit_trace: RTL and testbench
===============================

# commit_trace

Parametrised commit-trace monitor for the simulation core wrapper. Each cycle it takes up to `cwd` committed-instruction records, compacts them in slot order, stamps each with a global sequence number, and buffers them in a ring. A simulation consumer drains the ring over a valid/ready channel. Overflow is lossy but accounted for, and an optional watchdog flags commit stalls.

## Interface
Parameters:
- `cwd`, 4, commit slots per cycle (1..8)
- `depth`, 64, ring entries; power of two, ≥ 2·`cwd`
- `wdlim`, 1024, stall cycles before watchdog trips (≥ 1)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `cmt`  in  [cwd-1:0]  slot commit valid; holes allowed
- `cmt_pc`  in  [cwd-1:0][63:0]  slot PC
- `cmt_ir`  in  [cwd-1:0][31:0]  slot instruction
- `cmt_level`  in  [cwd-1:0][1:0]  slot privilege level
- `cmt_exc`  in  [cwd-1:0]  slot committed as exception/interrupt
- `rob_busy`  in  1  ROB non-empty this cycle
- `head_pc`  in  64  PC at ROB head
- `tr_valid`  out  1  trace entry available
- `tr_ready`  in  1  consumer accepts
- `tr_seq`  out  64  entry sequence number
- `tr_pc`  out  64  entry PC
- `tr_ir`  out  32  entry instruction
- `tr_level`  out  2  entry privilege level
- `tr_exc`  out  1  entry exception flag
- `occupancy`  out  $clog2(depth)+1  entries held
- `dropped`  out  64  total records dropped
- `ovf`  out  1  sticky: any drop since reset
- `wd_trip`  out  1  sticky watchdog trip
- `wd_pc`  out  64  `head_pc` captured at trip

## Operation
- Compaction: valid slots are packed lowest index first; k = popcount(`cmt`), 0..`cwd`.
- Sequence: internal counter `seq`. The record at packed position j gets `seq`+j. `seq` advances by k every cycle, whether or not the records are accepted, so drops appear to the consumer as gaps.
- Push: if k > 0 and `depth` − `occupancy` ≥ k, the k records are written at tail..tail+k−1 (mod `depth`) and tail advances by k.
- Drop: otherwise all k records are dropped atomically. `dropped` += k and `ovf` is set. Partial pushes are never made.
- Free-space test uses occupancy at the start of the cycle. A same-cycle pop does not create room.
- Pop: when `tr_valid` & `tr_ready`, head advances by 1.
- Occupancy next = occupancy + pushed − popped. Pointers are $clog2(depth) bits and wrap naturally.
- Outputs `tr_*` read the head entry combinationally from ring storage. `tr_valid` = `occupancy` ≠ 0.
- Watchdog: `stall_cnt` resets to 0 on any k > 0 or when `rob_busy` = 0; otherwise it increments, saturating at `wdlim`. On reaching `wdlim`, `wd_trip` ← 1 and `wd_pc` ← `head_pc` (first trip only). Cleared only by `rst`.

## Timing
- Reset values: `tr_valid` 0, `occupancy` 0, `dropped` 0, `ovf` 0, `wd_trip` 0, `wd_pc` 0, `seq` 0, pointers 0. `tr_*` data is don't-care while `tr_valid` = 0.
- Latency: a record pushed at edge t is visible on `tr_*` in cycle t+1 (if at head).
- Throughput: up to `cwd` in, 1 out per cycle.
- Channel rules: `tr_*` is held stable while `tr_valid` & ~`tr_ready`. An empty ring with a same-cycle push shows no bypass.
- Full + pop + push of k = 1: the push is dropped and the pop proceeds.
- Mid-run `rst` discards all buffered entries next cycle; no output is emitted in the reset cycle.
- Trip cycle: `wd_trip` rises at the edge where `stall_cnt` goes `wdlim`−1 → `wdlim`.

## Configuration
- `COMMIT_TRACE_WDOG_EN` defined: the watchdog is built as above.
- Undefined: no `stall_cnt` logic; `wd_trip` tied 0 and `wd_pc` tied 0. `rob_busy` and `head_pc` are unused.

## Structure
- Shared package `trace_pkg`: typedef `trace_ent_t` {seq 64, pc 64, ir 32, level 2, exc 1}, and constant `TRACE_SEQW` = 64.
- Sub-module `cmt_compact`: `cwd`-wide valid vector plus records in, packed records plus count k out; purely combinational.
- Ring storage is an unpacked `trace_ent_t` array inside `commit_trace`, with up to `cwd` write ports and 1 read port.

## Test plan
- Reset, then `cmt`=4'b1010 with PCs 0x1000/0x1004, `tr_ready`=1 → entries seq 0 pc 0x1000, then seq 1 pc 0x1004, in cycles t+1 and t+2.
- `depth`=8, `tr_ready`=0, push 4+4 then 1 → occupancy 8, `dropped`=1, `ovf`=1. After draining, seq values are 0..7; the next push starts at seq 9.
- Full ring, `tr_ready`=1, same-cycle push of 1 → record dropped, occupancy 7, `dropped` increments.
- Wrap test: 100 cycles of random `cmt`, with `tr_ready` high 70% of cycles and no drops → output seq contiguous 0..N−1 with PCs in order.
- With `COMMIT_TRACE_WDOG_EN` and `wdlim`=16: `rob_busy`=1, no commits for 16 cycles, `head_pc`=0x8000_0040 → `wd_trip`=1 and `wd_pc`=0x8000_0040. A commit at cycle 15 instead → no trip.
- Assert `rst` while occupancy 5 → next cycle `tr_valid`=0, occupancy 0, `dropped`=0, and the next record has seq 0.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared commit-trace record type and sequence width
package trace_pkg;
  localparam int TRACE_SEQW = 64;
  typedef struct packed {
    logic [TRACE_SEQW-1:0] seq;
    logic [63:0]           pc;
    logic [31:0]           ir;
    logic [1:0]            level;
    logic                  exc;
  } trace_ent_t;
endpackage

// File: rtl/cmt_compact.sv
// cmt_compact: packs valid commit slots lowest index first and stamps sequence numbers
module cmt_compact
  import trace_pkg::*;
#(
  parameter int cwd = 4,
  parameter int kw  = $clog2(cwd + 1)
) (
  input  logic [cwd-1:0]           vld,
  input  logic [cwd-1:0][63:0]     pc,
  input  logic [cwd-1:0][31:0]     ir,
  input  logic [cwd-1:0][1:0]      level,
  input  logic [cwd-1:0]           exc,
  input  logic [TRACE_SEQW-1:0]    base,
  output trace_ent_t [cwd-1:0]     ents,
  output logic [kw-1:0]            k
);
  always_comb begin
    int n;
    ents = '0;
    n = 0;
    for (int i = 0; i < cwd; i++) begin
      if (vld[i]) begin
        for (int j = 0; j < cwd; j++)
          if (j == n) ents[j] = '{seq: base + TRACE_SEQW'(n), pc: pc[i], ir: ir[i], level: level[i], exc: exc[i]};
        n = n + 1;
      end
    end
    k = kw'(n);
  end
endmodule

// File: rtl/commit_trace.sv
// commit_trace: commit-trace ring with lossy overflow accounting; COMMIT_TRACE_WDOG_EN builds the stall watchdog
module commit_trace
  import trace_pkg::*;
#(
  parameter int cwd   = 4,
  parameter int depth = 64,
  parameter int wdlim = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [cwd-1:0]            cmt,
  input  logic [cwd-1:0][63:0]      cmt_pc,
  input  logic [cwd-1:0][31:0]      cmt_ir,
  input  logic [cwd-1:0][1:0]       cmt_level,
  input  logic [cwd-1:0]            cmt_exc,
  input  logic                      rob_busy,
  input  logic [63:0]               head_pc,
  output logic                      tr_valid,
  input  logic                      tr_ready,
  output logic [63:0]               tr_seq,
  output logic [63:0]               tr_pc,
  output logic [31:0]               tr_ir,
  output logic [1:0]                tr_level,
  output logic                      tr_exc,
  output logic [$clog2(depth):0]    occupancy,
  output logic [63:0]               dropped,
  output logic                      ovf,
  output logic                      wd_trip,
  output logic [63:0]               wd_pc
);
  localparam int aw = $clog2(depth);
  localparam int ow = aw + 1;
  localparam int kw = $clog2(cwd + 1);
  trace_ent_t ring [depth];
  trace_ent_t [cwd-1:0] ents;
  trace_ent_t head_ent;
  logic [kw-1:0] k;
  logic [aw-1:0] head, tail;
  logic [TRACE_SEQW-1:0] seq;
  logic push, pop;
  cmt_compact #(.cwd(cwd), .kw(kw)) u_compact (
    .vld(cmt), .pc(cmt_pc), .ir(cmt_ir), .level(cmt_level), .exc(cmt_exc),
    .base(seq), .ents(ents), .k(k)
  );
  // room is judged on start-of-cycle occupancy; a same-cycle pop never makes space
  assign push = (k != '0) && ((ow'(depth) - occupancy) >= ow'(k));
  assign pop = tr_valid && tr_ready;
  assign tr_valid = occupancy != '0;
  assign head_ent = ring[head];
  assign tr_seq = head_ent.seq;
  assign tr_pc = head_ent.pc;
  assign tr_ir = head_ent.ir;
  assign tr_level = head_ent.level;
  assign tr_exc = head_ent.exc;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occupancy <= '0;
      seq <= '0;
      dropped <= '0;
      ovf <= 1'b0;
    end else begin
      seq <= seq + TRACE_SEQW'(k);
      if (push) tail <= tail + aw'(k);
      if (!push && k != '0) begin
        dropped <= dropped + 64'(k);
        ovf <= 1'b1;
      end
      if (pop) head <= head + 1'b1;
      occupancy <= occupancy + (push ? ow'(k) : '0) - ow'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push && !rst)
      for (int j = 0; j < cwd; j++)
        if (j < int'(k)) ring[tail + aw'(j)] <= ents[j];
`ifdef COMMIT_TRACE_WDOG_EN
  localparam int sw = $clog2(wdlim + 1);
  logic [sw-1:0] stall_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      wd_trip <= 1'b0;
      wd_pc <= '0;
    end else begin
      stall_cnt <= (k != '0 || !rob_busy) ? '0 : (stall_cnt == sw'(wdlim) ? stall_cnt : stall_cnt + 1'b1);
      if (!wd_trip && k == '0 && rob_busy && stall_cnt == sw'(wdlim - 1)) begin
        wd_trip <= 1'b1;
        wd_pc <= head_pc;
      end
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^{rob_busy, head_pc};
  assign wd_trip = 1'b0;
  assign wd_pc = '0;
`endif
endmodule

// File: tb/tb_commit_trace.sv
// tb_commit_trace: scoreboard bench for commit_trace (cwd 4, depth 8, wdlim 16)
module tb_commit_trace;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] cmt = '0;
  logic [3:0][63:0] cmt_pc = '0;
  logic [3:0][31:0] cmt_ir = '0;
  logic [3:0][1:0] cmt_level = '0;
  logic [3:0] cmt_exc = '0;
  logic rob_busy = 1'b0;
  logic [63:0] head_pc = '0;
  logic tr_valid, tr_ready = 1'b0;
  logic [63:0] tr_seq, tr_pc;
  logic [31:0] tr_ir;
  logic [1:0] tr_level;
  logic tr_exc;
  logic [3:0] occupancy;
  logic [63:0] dropped, wd_pc;
  logic ovf, wd_trip;
  int errors = 0, checks = 0;
  int mocc = 0, mdrop = 0;
  logic movf = 1'b0;
  logic [63:0] mseq = '0, pcb = 64'h1000;
  logic [162:0] q [$];
  commit_trace #(.cwd(4), .depth(8), .wdlim(16)) dut (
    .clk(clk), .rst(rst), .cmt(cmt), .cmt_pc(cmt_pc), .cmt_ir(cmt_ir),
    .cmt_level(cmt_level), .cmt_exc(cmt_exc), .rob_busy(rob_busy), .head_pc(head_pc),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_seq(tr_seq), .tr_pc(tr_pc),
    .tr_ir(tr_ir), .tr_level(tr_level), .tr_exc(tr_exc), .occupancy(occupancy),
    .dropped(dropped), .ovf(ovf), .wd_trip(wd_trip), .wd_pc(wd_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    cmt = '0;
    tr_ready = 1'b0;
    rob_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mocc = 0;
    mdrop = 0;
    movf = 1'b0;
    mseq = '0;
    q.delete();
  endtask
  // one cycle: drive at negedge, score the head, update the model, return #1 after the edge
  task automatic step(input logic [3:0] c, input logic rdy);
    int n, k;
    logic pop;
    logic [162:0] e;
    @(negedge clk);
    cmt = c;
    tr_ready = rdy;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cmt_pc[i] = c[i] ? pcb + 64'(4 * n) : 64'hdead;
      cmt_ir[i] = $urandom;
      cmt_level[i] = 2'($urandom);
      cmt_exc[i] = 1'($urandom);
      n += int'(c[i]);
    end
    pcb += 64'(4 * n);
    k = n;
    chk("valid", tr_valid, mocc != 0);
    chk("occ", occupancy, mocc);
    chk("dropped", dropped, mdrop);
    chk("ovf", ovf, movf);
    pop = (mocc != 0) && rdy;
    if (pop) begin
      e = q.pop_front();
      chk("ent", {tr_seq, tr_pc, tr_ir, tr_level, tr_exc}, e);
    end
    if (k > 0) begin
      if (8 - mocc >= k) begin
        n = 0;
        for (int i = 0; i < 4; i++)
          if (c[i]) begin
            q.push_back({mseq + 64'(n), cmt_pc[i], cmt_ir[i], cmt_level[i], cmt_exc[i]});
            n++;
          end
        mocc += k;
      end else begin
        mdrop += k;
        movf = 1'b1;
      end
    end
    mseq += 64'(k);
    if (pop) mocc--;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] c;
    repeat (2) @(posedge clk);
    reset_dut();
    chk("rst_valid", tr_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_wd_trip", wd_trip, 0);
    chk("rst_wd_pc", wd_pc, 0);
    pcb = 64'h1000;
    step(4'b1010, 1'b1);
    chk("first_seq", tr_seq, 0);
    chk("first_pc", tr_pc, 64'h1000);
    step(4'b0000, 1'b1);
    chk("second_seq", tr_seq, 1);
    chk("second_pc", tr_pc, 64'h1004);
    step(4'b0000, 1'b1);
    chk("empty_after", tr_valid, 0);
    reset_dut();
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b0001, 1'b0);
    chk("ovf_occ", occupancy, 8);
    chk("ovf_dropped", dropped, 1);
    chk("ovf_flag", ovf, 1);
    repeat (8) step(4'b0000, 1'b1);
    step(4'b0001, 1'b0);
    chk("gap_seq", tr_seq, 9);
    step(4'b0000, 1'b1);
    reset_dut();
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b0001, 1'b1);
    chk("fullpop_occ", occupancy, 7);
    chk("fullpop_dropped", dropped, 1);
    repeat (8) step(4'b0000, 1'b1);
    reset_dut();
    for (int cyc = 0; cyc < 100; cyc++) begin
      for (int i = 0; i < 4; i++) c[i] = ($urandom_range(3) == 0);
      if ($countones(c) > 8 - mocc) c = '0;
      step(c, $urandom_range(99) < 70);
    end
    repeat (12) step(4'b0000, 1'b1);
    chk("wrap_nodrop", dropped, 0);
    chk("wrap_drained", q.size(), 0);
`ifdef COMMIT_TRACE_WDOG_EN
    reset_dut();
    rob_busy = 1'b1;
    head_pc = 64'h8000_0040;
    repeat (15) @(posedge clk);
    #1;
    chk("wd_early", wd_trip, 0);
    @(posedge clk);
    #1;
    chk("wd_trip", wd_trip, 1);
    chk("wd_pc", wd_pc, 64'h8000_0040);
    reset_dut();
    rob_busy = 1'b1;
    repeat (14) @(posedge clk);
    @(negedge clk);
    cmt = 4'b0001;
    @(negedge clk);
    cmt = 4'b0000;
    @(posedge clk);
    #1;
    chk("wd_kick", wd_trip, 0);
`else
    reset_dut();
    rob_busy = 1'b1;
    head_pc = 64'h8000_0040;
    repeat (20) @(posedge clk);
    #1;
    chk("wd_off_trip", wd_trip, 0);
    chk("wd_off_pc", wd_pc, 0);
`endif
    reset_dut();
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b0001, 1'b0);
    repeat (3) step(4'b0000, 1'b1);
    chk("pre_rst_occ", occupancy, 5);
    reset_dut();
    chk("midrst_valid", tr_valid, 0);
    chk("midrst_occ", occupancy, 0);
    chk("midrst_dropped", dropped, 0);
    step(4'b0001, 1'b0);
    chk("midrst_seq", tr_seq, 0);
    step(4'b0000, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
